// File: rtl/detect_seq_configurable.sv
// Runtime-programmable serial sequence detector with overlapping/non-overlapping match modes.
// Define DETECT_SEQ_MATCH_COUNTER_EN to build the saturating match counter; otherwise match_count is tied to 0.
module detect_seq_configurable #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               a_valid,
  input  logic               a,
  output logic               detected,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic [1:0] {
    UNCFG,
    FILL,
    HUNT
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               match;
  logic               accept;
  logic               cfg_legal;

  // Only the low len bits of the shifted history take part in the comparison.
  always_comb begin
    hist_n    = {hist[MAX_LEN-2:0], a};
    fill_n    = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match     = (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
    accept    = a_valid && !cfg_valid && (state != UNCFG);
    cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  end

  // A config beat always takes priority over a data beat in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= UNCFG;
      hist     <= '0;
      fill     <= '0;
      pat      <= '0;
      len      <= '0;
      ovl      <= 1'b0;
      detected <= 1'b0;
      armed    <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      detected <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_valid) begin
        if (cfg_legal) begin
          pat   <= cfg_pattern;
          len   <= cfg_len;
          ovl   <= cfg_overlap;
          hist  <= '0;
          fill  <= '0;
          state <= FILL;
          armed <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (accept) begin
        hist <= hist_n;
        if (match) begin
          detected <= 1'b1;
          if (ovl) begin
            fill  <= fill_n;
            state <= HUNT;
          end else begin
            fill  <= '0;
            state <= FILL;
          end
        end else begin
          fill  <= fill_n;
          state <= (fill_n >= len) ? HUNT : FILL;
        end
      end
    end
  end

`ifdef DETECT_SEQ_MATCH_COUNTER_EN
  logic             hit;
  logic [CNT_W-1:0] count;

  assign hit = accept && match;

  // The count moves on the same edge that raises detected, so it already includes the visible pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (cfg_valid && cfg_legal) begin
      count <= '0;
    end else if (hit && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign match_count = count;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_detect_seq_configurable.sv
// Self-checking bench for detect_seq_configurable: directed scenarios then randomized traffic
// compared against a queue-based model of the accepted bit stream.
module tb_detect_seq_configurable;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               cfg_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               a_valid;
  logic               a;
  logic               detected;
  logic               armed;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  int vectors;
  int miscompares;

  // Reference model: the bits counted toward a match since the last clear, oldest first.
  bit                 bits[$];
  bit                 mArmed;
  logic [MAX_LEN-1:0] mPat;
  int                 mLen;
  bit                 mOvl;
  bit                 expDet;
  bit                 expErr;
  int                 expCnt;

  detect_seq_configurable #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .a_valid    (a_valid),
    .a          (a),
    .detected   (detected),
    .armed      (armed),
    .cfg_err    (cfg_err),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit tailMatches();
    int base;
    if (bits.size() < mLen) return 1'b0;
    base = bits.size() - mLen;
    for (int k = 0; k < mLen; k++) begin
      if (bits[base + k] != mPat[mLen - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelEdge();
    expDet = 1'b0;
    expErr = 1'b0;
    if (!rst_n) begin
      mArmed = 1'b0;
      mPat   = '0;
      mLen   = 0;
      mOvl   = 1'b0;
      bits.delete();
      expCnt = 0;
    end else if (cfg_valid) begin
      if (cfg_len >= 1 && int'(cfg_len) <= MAX_LEN) begin
        mArmed = 1'b1;
        mPat   = cfg_pattern;
        mLen   = int'(cfg_len);
        mOvl   = cfg_overlap;
        bits.delete();
        expCnt = 0;
      end else begin
        expErr = 1'b1;
      end
    end else if (a_valid && mArmed) begin
      bits.push_back(a);
      if (bits.size() > MAX_LEN) void'(bits.pop_front());
      if (tailMatches()) begin
        expDet = 1'b1;
`ifdef DETECT_SEQ_MATCH_COUNTER_EN
        if (expCnt < CNT_MAX) expCnt++;
`endif
        if (!mOvl) bits.delete();
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (detected === expDet) else begin
      miscompares++;
      $error("[TB] FAIL %s detected: observed %b expected %b", tag, detected, expDet);
    end
    vectors++;
    assert (armed === mArmed) else begin
      miscompares++;
      $error("[TB] FAIL %s armed: observed %b expected %b", tag, armed, mArmed);
    end
    vectors++;
    assert (cfg_err === expErr) else begin
      miscompares++;
      $error("[TB] FAIL %s cfg_err: observed %b expected %b", tag, cfg_err, expErr);
    end
    vectors++;
    assert (match_count === CNT_W'(expCnt)) else begin
      miscompares++;
      $error("[TB] FAIL %s match_count: observed %0d expected %0d", tag, match_count, expCnt);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, check on the falling edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit cv,
                               input logic [MAX_LEN-1:0] cp, input logic [LEN_W-1:0] cl,
                               input bit co, input bit av, input bit ab);
    rst_n       = rst;
    cfg_valid   = cv;
    cfg_pattern = cp;
    cfg_len     = cl;
    cfg_overlap = co;
    a_valid     = av;
    a           = ab;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic beat(input string tag, input bit ab);
    applyStimulus(tag, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, ab);
  endtask

  task automatic configure(input string tag, input logic [MAX_LEN-1:0] cp,
                           input logic [LEN_W-1:0] cl, input bit co);
    applyStimulus(tag, 1'b1, 1'b1, cp, cl, co, 1'b0, 1'b0);
  endtask

  task automatic doReset(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic streamBits(input string tag, input logic [15:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) beat(tag, word[i]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    a_valid     = 1'b0;
    a           = 1'b0;

    doReset("reset");
    doReset("reset");
    idle("reset_idle");

    for (int i = 0; i < 10; i++) beat("uncfg", 1'($urandom));
    configure("uncfg_bad", 8'h01, 4'd0, 1'b0);
    beat("uncfg_after_bad", 1'b1);

    configure("ovl_cfg", 8'b0011_0011, 4'd6, 1'b1);
    streamBits("ovl", 16'b11_0011_0011, 10);
    idle("ovl_tail");

    configure("novl_cfg", 8'b0011_0011, 4'd6, 1'b0);
    streamBits("novl", 16'b11_0011_0011, 10);
    idle("novl_tail");

    configure("stall_cfg", 8'b0000_1010, 4'd4, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] p;
      p = 4'b1010;
      beat("stall_beat", p[i]);
      for (int g = 0; g < 3; g++) idle("stall_gap");
    end

    streamBits("pre_rst", 16'b101, 3);
    doReset("mid_rst");
    streamBits("post_rst", 16'b0101_1010, 8);

    configure("coll_base", 8'b0000_1111, 4'd4, 1'b1);
    beat("coll_base", 1'b1);
    applyStimulus("collide", 1'b1, 1'b1, 8'b0000_0011, 4'd2, 1'b0, 1'b1, 1'b1);
    beat("coll_b1", 1'b1);
    beat("coll_b2", 1'b1);

    beat("bad_pre", 1'b1);
    configure("bad_len0", 8'hFF, 4'd0, 1'b1);
    beat("bad_post0", 1'b1);
    applyStimulus("bad_len9", 1'b1, 1'b1, 8'h00, 4'd9, 1'b1, 1'b1, 1'b0);
    beat("bad_post9a", 1'b1);
    beat("bad_post9b", 1'b1);

    configure("sat_cfg", 8'b0000_0001, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) beat("sat", 1'b1);
    idle("sat_tail");
    beat("sat_zero", 1'b0);

    configure("full_cfg", 8'b1011_0010, 4'd8, 1'b1);
    streamBits("full", 16'b1011_0010_1101_1001, 16);

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        doReset("rnd_rst");
      end else if (r < 6) begin
        applyStimulus("rnd_cfg", 1'b1, 1'b1, 8'($urandom), 4'($urandom_range(0, 15)),
                      1'($urandom), 1'($urandom), 1'($urandom));
      end else if (r < 8) begin
        applyStimulus("rnd_cfg_short", 1'b1, 1'b1, 8'($urandom), 4'($urandom_range(1, 3)),
                      1'($urandom), 1'b0, 1'b0);
      end else begin
        applyStimulus("rnd_beat", 1'b1, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
